// File: rtl/lfsr64_pkg.sv
// Shared definitions for the 64-bit LFSR generator and checker: seed, step function
// and the checker's acquisition state encoding.
package lfsr64_pkg;

  localparam logic [63:0] LFSR64_SEED = 64'hdeadbeef12345678;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } acq_state_e;

  // One generator step: shift left, feedback from taps 63, 62, 60, 59.
  function automatic logic [63:0] lfsr64_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

endpackage

// File: rtl/lfsr64_checker.sv
// LFSR64 stream checker: acquires the generator state, verifies LOCK_CNT predicted steps,
// then flywheels and counts mismatches. Optional beat_count under LFSR64_CHK_BEATCNT_EN.
module lfsr64_checker
  import lfsr64_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       acq_state
`ifdef LFSR64_CHK_BEATCNT_EN
  ,
  output logic [31:0]      beat_count
`endif
);

  acq_state_e       state_q, state_d;
  logic [63:0]      ref_q, ref_d;
  logic [63:0]      ref_next;
  logic [3:0]       run_q, run_d;
  logic [3:0]       miss_q, miss_d;
  logic             err_pulse_d;
  logic [ERR_W-1:0] err_count_d;

  assign ref_next  = lfsr64_step(ref_q);
  assign acq_state = state_q;

  // NOTE: combinational next-state logic uses blocking '=' with every target defaulted
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count;

    case (state_q)
      ACQUIRE: begin
        // An all-zero word is the LFSR lockup state and can never seed a valid stream.
        if (in_valid && in_data != '0) begin
          ref_d   = in_data;
          run_d   = '0;
          state_d = VERIFY;
        end
      end

      VERIFY: begin
        if (in_valid) begin
          if (in_data == ref_next) begin
            run_d = run_q + 4'd1;
            ref_d = in_data;
            if (run_d == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (in_data != '0) begin
            ref_d = in_data;
            run_d = '0;
          end else begin
            run_d   = '0;
            state_d = ACQUIRE;
          end
        end
      end

      LOCKED: begin
        if (in_valid) begin
          // Flywheel: the reference advances on its own, never re-seeded from the line.
          ref_d = ref_next;
          if (in_data == ref_next) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count != '1) err_count_d = err_count + 1'b1;
            if (miss_q + 4'd1 == 4'(LOSS_CNT)) begin
              state_d = ACQUIRE;
              miss_d  = '0;
              run_d   = '0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
      end

      default: state_d = ACQUIRE;
    endcase

    if (clear) err_count_d = '0;
  end

  // NOTE: reset is synchronous and active-high, so it appears only inside the clocked
  // branch and a beat presented alongside it is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACQUIRE;
      ref_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
    end
  end

`ifdef LFSR64_CHK_BEATCNT_EN
  always_ff @(posedge clk) begin
    if (rst || clear) beat_count <= '0;
    else if (in_valid && state_q == LOCKED) beat_count <= beat_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_lfsr64_checker.sv
// Self-checking bench for lfsr64_checker: table-driven vectors, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_lfsr64_checker;

  localparam logic [63:0] SEED = 64'hdeadbeef12345678;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, a_clear, b_valid, b_clear;
  logic [63:0] a_data, b_data;
  logic        a_locked, a_pulse, b_locked, b_pulse;
  logic [15:0] a_err;
  logic [3:0]  b_err;
  logic [1:0]  a_state, b_state;
`ifdef LFSR64_CHK_BEATCNT_EN
  logic [31:0] a_beats, b_beats;
`endif

  lfsr64_checker dut (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .clear(a_clear),
    .locked(a_locked), .err_pulse(a_pulse), .err_count(a_err), .acq_state(a_state)
`ifdef LFSR64_CHK_BEATCNT_EN
    , .beat_count(a_beats)
`endif
  );

  lfsr64_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .clear(b_clear),
    .locked(b_locked), .err_pulse(b_pulse), .err_count(b_err), .acq_state(b_state)
`ifdef LFSR64_CHK_BEATCNT_EN
    , .beat_count(b_beats)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Generator step: next bit is the parity of the tapped bits.
  function automatic logic [63:0] g(input logic [63:0] s);
    logic fb;
    fb = ^(s & TAPS);
    return (s << 1) | 64'(fb);
  endfunction

  // Behavioural model of the checker's observable behaviour.
  typedef struct {
    int          mode;   // 0 acquire, 1 verify, 2 locked
    logic [63:0] r;
    int          run;
    int          miss;
    int          errc;
    bit          pulse;
    int unsigned beats;
  } model_t;

  task automatic model_step(input model_t mi, input bit rs, input bit v, input logic [63:0] d,
                            input bit clr, input int lock_n, input int loss_n, input int errmax,
                            output model_t mo);
    mo = mi;
    mo.pulse = 0;
    if (rs) begin
      mo.mode = 0; mo.r = '0; mo.run = 0; mo.miss = 0; mo.errc = 0; mo.beats = 0;
      return;
    end
    if (v) begin
      if (mi.mode == 0) begin
        if (d != 0) begin mo.r = d; mo.run = 0; mo.mode = 1; end
      end else if (mi.mode == 1) begin
        if (d == g(mi.r)) begin
          mo.run = mi.run + 1; mo.r = d;
          if (mo.run == lock_n) begin mo.mode = 2; mo.miss = 0; end
        end else if (d != 0) begin
          mo.r = d; mo.run = 0;
        end else begin
          mo.mode = 0; mo.run = 0;
        end
      end else begin
        mo.beats = mi.beats + 1;
        mo.r = g(mi.r);
        if (d == mo.r) mo.miss = 0;
        else begin
          mo.pulse = 1;
          mo.errc = (mi.errc + 1 > errmax) ? errmax : mi.errc + 1;
          mo.miss = mi.miss + 1;
          if (mo.miss == loss_n) begin mo.mode = 0; mo.miss = 0; mo.run = 0; end
        end
      end
    end
    if (clr) begin mo.errc = 0; mo.beats = 0; end
  endtask

  typedef struct {
    bit          valid;
    int          gi;
    logic [63:0] flip;
    bit          clr;
    bit          e_locked;
    bit          e_pulse;
    int          e_err;
    int          e_state;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] gseq[24];

  task automatic add(input bit v, input int gi, input logic [63:0] flip, input bit clr,
                     input bit el, input bit ep, input int ee, input int es);
    vec_t t;
    t.valid = v; t.gi = gi; t.flip = flip; t.clr = clr;
    t.e_locked = el; t.e_pulse = ep; t.e_err = ee; t.e_state = es;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0; a_clear = 1'b0; a_data = '0;
    b_valid = 1'b0; b_clear = 1'b0; b_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_a(input string tag, input bit el, input bit ep, input int ee, input int es);
    check({tag, " locked"}, 64'(a_locked), 64'(el));
    check({tag, " err_pulse"}, 64'(a_pulse), 64'(ep));
    check({tag, " err_count"}, 64'(a_err), 64'(ee));
    check({tag, " acq_state"}, 64'(a_state), 64'(es));
  endtask

  task automatic chk_b(input string tag, input bit el, input bit ep, input int ee, input int es);
    check({tag, " locked"}, 64'(b_locked), 64'(el));
    check({tag, " err_pulse"}, 64'(b_pulse), 64'(ep));
    check({tag, " err_count"}, 64'(b_err), 64'(ee));
    check({tag, " acq_state"}, 64'(b_state), 64'(es));
  endtask

  task automatic drive_a(input bit v, input logic [63:0] d, input bit clr);
    a_valid = v; a_data = d; a_clear = clr;
    tick();
  endtask

  task automatic drive_b(input bit v, input logic [63:0] d, input bit clr);
    b_valid = v; b_data = d; b_clear = clr;
    tick();
  endtask

  initial begin
    model_t      m, mn;
    logic [63:0] w, x, gen;
    bit          v, clr, rs;
    int          r;

    gseq[0] = SEED;
    for (int i = 1; i < 24; i++) gseq[i] = g(gseq[i - 1]);
    check("g(seed)", gseq[1], 64'hbd5b7dde2468acf0);

    // Acquire/verify/lock, single flywheel error, idle gap, then loss of lock.
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 2, 0, 0, 0, 0, 0, 1);
    add(1, 3, 0, 0, 0, 0, 0, 1);
    add(1, 4, 0, 0, 1, 0, 0, 2);
    add(1, 5, 0, 0, 1, 0, 0, 2);
    add(1, 6, 64'h1, 0, 1, 1, 1, 2);
    add(1, 7, 0, 0, 1, 0, 1, 2);
    add(1, 8, 0, 0, 1, 0, 1, 2);
    for (int i = 0; i < 10; i++) add(0, 9, 64'h5555_0000_aaaa_0000, 0, 1, 0, 1, 2);
    add(1, 9, 0, 0, 1, 0, 1, 2);
    add(1, 10, 0, 0, 1, 0, 1, 2);
    add(1, 11, 0, 1, 1, 0, 0, 2);
    add(1, 12, 64'h1 << 40, 0, 1, 1, 1, 2);
    add(1, 13, 64'h1 << 7, 0, 1, 1, 2, 2);
    add(1, 14, 64'h3, 0, 0, 1, 3, 0);
    add(1, 15, 0, 0, 0, 0, 3, 1);

    do_reset();
    chk_a("reset", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);
    foreach (vecs[i]) begin
      drive_a(vecs[i].valid, gseq[vecs[i].gi] ^ vecs[i].flip, vecs[i].clr);
      chk_a($sformatf("vec%0d", i), vecs[i].e_locked, vecs[i].e_pulse, vecs[i].e_err,
            vecs[i].e_state);
    end

    // All-zero words never leave ACQUIRE.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_a(1, 64'h0, 0);
      chk_a($sformatf("zero%0d", i), 0, 0, 0, 0);
    end

    // VERIFY reseeds on a wrong word, falls back to ACQUIRE on zero, locks after re-verifying.
    w = 64'h0123_4567_89ab_cdef;
    x = 64'h0000_0000_0000_1111;
    drive_a(1, w, 0);       chk_a("reseed w", 0, 0, 0, 1);
    drive_a(1, x, 0);       chk_a("reseed x", 0, 0, 0, 1);
    drive_a(1, 64'h0, 0);   chk_a("verify zero", 0, 0, 0, 0);
    drive_a(1, x, 0);       chk_a("reacq x", 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      x = g(x);
      drive_a(1, x, 0);
      chk_a($sformatf("relock%0d", i), i == 3, 0, 0, i == 3 ? 2 : 1);
    end

    // Reset mid-lock discards the corrupted beat presented with it.
    rst = 1'b1;
    drive_a(1, g(x) ^ 64'hff, 0);
    rst = 1'b0;
    chk_a("rst midlock", 0, 0, 0, 0);

    // Saturation on a 4-bit counter with LOSS_CNT=15.
    for (int i = 0; i < 5; i++) drive_b(1, gseq[i], 0);
    chk_b("sat lock", 1, 0, 0, 2);
    for (int i = 0; i < 15; i++) begin
      drive_b(1, gseq[5 + i] ^ 64'h8, 0);
      if (i == 13) chk_b("sat miss14", 1, 1, 14, 2);
    end
    chk_b("sat miss15", 0, 1, 15, 0);
    for (int i = 0; i < 5; i++) drive_b(1, gseq[i], 0);
    chk_b("sat relock", 1, 0, 15, 2);
    drive_b(1, gseq[5] ^ 64'h1, 0);  chk_b("sat miss16", 1, 1, 15, 2);
    drive_b(1, gseq[6] ^ 64'h1, 0);  chk_b("sat miss17", 1, 1, 15, 2);
    drive_b(1, gseq[7] ^ 64'h1, 1);  chk_b("clear on miss", 1, 1, 0, 2);
    drive_b(1, gseq[8], 0);          chk_b("after clear", 1, 0, 0, 2);
    drive_b(0, 64'h0, 0);

    // Randomized stream with corruption, zeros, foreign words, clears and resets.
    do_reset();
    m.mode = 0; m.r = '0; m.run = 0; m.miss = 0; m.errc = 0; m.pulse = 0; m.beats = 0;
    gen = {$urandom, $urandom} | 64'h1;
    for (int c = 0; c < 800; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      rs  = ($urandom_range(0, 150) == 0);
      r   = $urandom_range(0, 19);
      if (r < 15) begin
        gen = g(gen); w = gen;
      end else if (r < 17) begin
        gen = g(gen); w = gen ^ (64'h1 << $urandom_range(0, 63));
      end else if (r == 17) begin
        w = 64'h0;
      end else begin
        w = {$urandom, $urandom};
      end
      rst = rs;
      drive_a(v, w, clr);
      rst = 1'b0;
      model_step(m, rs, v, w, clr, 4, 3, 16'hffff, mn);
      m = mn;
      chk_a($sformatf("rnd%0d", c), m.mode == 2, m.pulse, m.errc, m.mode);
`ifdef LFSR64_CHK_BEATCNT_EN
      check($sformatf("rnd%0d beat_count", c), 64'(a_beats), 64'(m.beats));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr64_checker.md
LFSR64_CHECKER -- requirements
Module: lfsr64_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive predicted matches needed to declare lock (range 1..15).
REQ-002 Parameter LOSS_CNT, default 3: consecutive mismatches while locked that drop lock (range 1..15).
REQ-003 Parameter ERR_W, default 16: width of the error counter.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_data carries one generator step this cycle.
REQ-007 in_data  input  64  observed generator state word.
REQ-008 clear  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  checker is in LOCKED.
REQ-010 err_pulse  output  1  one-cycle flag for a mismatched beat while locked.
REQ-011 err_count  output  ERR_W  saturating count of locked mismatches.
REQ-012 acq_state  output  2  current FSM state encoding.

Function
REQ-013 Step function G(s) SHALL be {s[62:0], s[63]^s[62]^s[60]^s[59]}, identical to the team generator.
REQ-014 FSM states SHALL be ACQUIRE=0, VERIFY=1, LOCKED=2; encoding 3 is unreachable and SHALL recover to ACQUIRE.
REQ-015 Cycles with in_valid=0 SHALL change no state, register or output except err_pulse (deasserted).
REQ-016 ACQUIRE, valid nonzero word: ref <= in_data, run <= 0, go VERIFY; an all-zero word (LFSR lockup) SHALL be ignored.
REQ-017 VERIFY, valid beat: if in_data==G(ref) then run++, ref <= in_data, enter LOCKED when run reaches LOCK_CNT; else reseed ref <= in_data (if nonzero), run <= 0, stay VERIFY (zero word: go ACQUIRE).
REQ-018 LOCKED, valid beat: ref <= G(ref) (flywheel, independent of in_data); match clears miss run; mismatch asserts err_pulse, increments err_count, increments miss run.
REQ-019 When the miss run reaches LOSS_CNT, the checker SHALL go ACQUIRE on that beat; the counting of that mismatch still applies.
REQ-020 All outputs SHALL be registered; err_pulse and the locked/acq_state changes SHALL appear exactly one cycle after the causing beat.
REQ-021 err_count SHALL saturate at all-ones and never wrap.
REQ-022 clear SHALL zero err_count the next cycle with priority over a simultaneous increment; err_pulse still reflects that beat.
REQ-023 Mismatches outside LOCKED SHALL never assert err_pulse or change err_count.

Reset
REQ-024 rst SHALL force ACQUIRE, ref=0, run=0, miss run=0, locked=0, err_pulse=0, err_count=0, acq_state=0, and any optional counter=0.
REQ-025 rst asserted mid-lock SHALL take effect on the next edge and discard the beat presented that cycle.

Configuration
REQ-026 Macro LFSR64_CHK_BEATCNT_EN defined: add output beat_count (32 bits), counting valid beats while LOCKED, wrapping at 2^32, cleared by rst and clear.
REQ-027 Macro undefined: beat_count port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package lfsr64_pkg SHALL hold the 64-bit seed constant 64'hdeadbeef12345678, the step function G, and the FSM state enumeration, also for use by the generator.
REQ-029 The design SHALL be one module with no sub-module; G SHALL come from the package, not be duplicated.

Verification
REQ-030 Reset, then valid words deadbeef12345678, bd5b7dde2468acf0, then the next 3 G steps -> locked=1 one cycle after the 4th matched beat; err_count=0.
REQ-031 Locked, one word with bit 0 flipped, then correct words -> one err_pulse, err_count=1, locked stays 1, and subsequent matches do not raise err_pulse (flywheel).
REQ-032 Locked, 3 consecutive corrupted words -> err_count=3, locked=0 and acq_state=0 one cycle after the 3rd.
REQ-033 Locked, in_valid held low for 10 cycles, then stream resumes at the correct word -> no err_pulse; lock retained.
REQ-034 Reset, 5 all-zero valid words -> acq_state stays 0; locked=0.
REQ-035 err_count forced near saturation (ERR_W=4, 17 locked mismatches with LOSS_CNT=15 and re-lock between them) -> err_count=15; clear coincident with a mismatch -> err_count=0.
